// File: rtl/mavg_pkg.sv
// mavg_pkg: shared sizing helpers and configuration checks for the
// moving-average filter.
//   sum_w()  : running-sum width, sample width plus log2 of window length
//   cnt_w()  : counter width for a modulo-N counter (min 1 bit)
//   cfg_ok() : legal LOG2_LEN (1..8) and DECIM (1..256)
//   q15_t    : default Q15 sample type (modules derive sample_t from DATA_W)
package mavg_pkg;

  localparam int DATA_W_DEF = 16;

  typedef logic signed [DATA_W_DEF-1:0] q15_t;

  function automatic int sum_w(input int data_w, input int log2_len);
    return data_w + log2_len;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit cfg_ok(input int log2_len, input int decim);
    return (log2_len >= 1) && (log2_len <= 8) && (decim >= 1) && (decim <= 256);
  endfunction

endpackage

// File: rtl/mavg_delay_line.sv
// mavg_delay_line: LEN-deep circular sample buffer with write pointer and
// fill tracking.
//   clk, rst_n : clock, async active-low reset (pointer/fill state only)
//   wr_en      : write din at wr_ptr and advance (caller masks with clear)
//   clear      : synchronous flush of pointer and fill state
//   din        : sample to write
//   dout_old   : sample at wr_ptr, i.e. the one about to be overwritten
//   full       : LEN samples accepted since reset/clear
//   full_nxt   : full will be set after an accepted write this cycle
module mavg_delay_line
  import mavg_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LOG2_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout_old,
  output logic              full,
  output logic              full_nxt
);

  localparam int LEN = 1 << LOG2_LEN;

  logic [DATA_W-1:0]   mem [LEN];
  logic [LOG2_LEN-1:0] wr_ptr;
  logic [LOG2_LEN:0]   fill_cnt;

  // Read happens before the write on the same edge.
  assign dout_old = mem[wr_ptr];
  assign full_nxt = full | (fill_cnt == (LOG2_LEN+1)'(LEN-1));

  // Contents are never reset; full masks stale entries out of the sum.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      full     <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      full     <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;  // natural wrap at LEN
      if (!full) fill_cnt <= fill_cnt + 1'b1;
      if (full_nxt) full <= 1'b1;
    end
  end

endmodule

// File: rtl/mavg_filter.sv
// mavg_filter: boxcar moving-average filter with output decimation.
//   clk, rst_n : clock, async active-low reset
//   ce         : accept data_in this edge
//   clear      : synchronous flush of window state, wins over ce
//   data_in    : signed sample, Q(DATA_W-1)
//   avg        : registered window mean
//   rdy        : one-cycle strobe when avg updates
// Optional: define MAVG_FILTER_ROUND_EN to round half toward +inf instead of
// flooring.
module mavg_filter
  import mavg_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LOG2_LEN = 3,
  parameter int DECIM    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] avg,
  output logic                     rdy
);

  localparam int SUM_W = sum_w(DATA_W, LOG2_LEN);
  localparam int DEC_W = cnt_w(DECIM);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  if (!cfg_ok(LOG2_LEN, DECIM)) begin : g_cfg_err
    $error("mavg_filter: LOG2_LEN must be 1..8 and DECIM 1..256");
  end

  logic             acc, dl_full, dl_full_nxt, full_after, ev;
  logic [DATA_W-1:0] old_raw;
  sample_t          old_s;
  sum_t             sum, sum_nxt, din_ext, old_ext, rnd, shr;
  logic [DEC_W-1:0] dec_cnt;

  assign acc = ce & ~clear;

  mavg_delay_line #(.DATA_W(DATA_W), .LOG2_LEN(LOG2_LEN)) u_dl (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (acc),
    .clear    (clear),
    .din      (data_in),
    .dout_old (old_raw),
    .full     (dl_full),
    .full_nxt (dl_full_nxt)
  );

  assign old_s      = sample_t'(old_raw);
  assign din_ext    = {{LOG2_LEN{data_in[DATA_W-1]}}, data_in};
  assign old_ext    = dl_full ? {{LOG2_LEN{old_s[DATA_W-1]}}, old_s} : '0;
  assign sum_nxt    = sum + din_ext - old_ext;
  assign full_after = acc & dl_full_nxt;
  assign ev         = full_after & (dec_cnt == '0);

`ifdef MAVG_FILTER_ROUND_EN
  // Sum headroom is LEN*(2^(DATA_W-1)) so adding LEN/2 cannot wrap.
  assign rnd = sum_nxt + sum_t'(1 << (LOG2_LEN-1));
`else
  assign rnd = sum_nxt;
`endif
  assign shr = rnd >>> LOG2_LEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      dec_cnt <= '0;
      avg     <= '0;
      rdy     <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (clear) begin
        sum     <= '0;
        dec_cnt <= '0;
      end else if (acc) begin
        sum <= sum_nxt;
        if (full_after)
          dec_cnt <= (dec_cnt == DEC_W'(DECIM-1)) ? '0 : dec_cnt + 1'b1;
        if (ev) begin
          avg <= shr[DATA_W-1:0];
          rdy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mavg_filter.md
Name: mavg_filter

Overview:
Parametrised boxcar moving-average filter for signed fixed-point (Q15 by default) sample streams. It is the next generation of the single-window averaging filter, adding configurable width, window length and output decimation, plus a synchronous clear. It sits after the sigma-delta decimator/CIC stage and feeds downstream processing with a rdy strobe per output.

Parameters:
DATA_W, 16, sample and output width, signed two's complement (Q(DATA_W-1)).
LOG2_LEN, 3, log2 of window length; LEN = 2**LOG2_LEN, legal range 1..8.
DECIM, 1, output decimation factor once the window is full; legal range 1..256.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  sample enable; data_in accepted on rising edge when high
clear  in  1  synchronous flush of window state, priority over ce
data_in  in  DATA_W  signed input sample
avg  out  DATA_W  signed window average, registered
rdy  out  1  one-cycle strobe: avg updated this cycle

Behaviour:
- Reset (rst_n low, async): avg=0, rdy=0, sum=0, wr_ptr=0, fill_cnt=0, full=0, dec_cnt=0. Delay-line contents need not be reset.
- Delay line: LEN x DATA_W circular buffer, wr_ptr wraps LEN-1 -> 0.
- Running sum width SUM_W = DATA_W+LOG2_LEN, signed; cannot overflow.
- Accepted sample (ce=1, clear=0): buf[wr_ptr]<=data_in; wr_ptr++; sum_next = sum + data_in - (full ? buf[wr_ptr] : 0); the old value is the one read before the write.
- Fill: fill_cnt counts accepted samples; full sets on the edge accepting sample LEN and stays set until clear/reset.
- Output event: accepted sample where full is set after the edge and dec_cnt==0. On the event, avg <= sum_next >>> LOG2_LEN (arithmetic, floor) and rdy=1 for exactly that cycle. Otherwise avg holds and rdy=0.
- dec_cnt: increments mod DECIM on each accepted sample once full is set after the edge. First output is on sample LEN, then every DECIM samples. DECIM=1 gives an output on every sample after fill.
- Latency: avg/rdy valid in the cycle after the accepting edge, with no pipeline bubble.
- ce=0: all state holds; rdy=0.
- clear=1: sum, wr_ptr, fill_cnt, full and dec_cnt go to 0; avg holds its last value; rdy=0. If ce=1 in the same cycle, the sample is discarded.
- Reset mid-window: all progress is lost; the window refills from zero.
- Full-scale inputs: all -2**(DATA_W-1) gives avg=-2**(DATA_W-1); all 2**(DATA_W-1)-1 gives that value exactly.

Optional Feature:
Macro MAVG_FILTER_ROUND_EN.
- Defined: avg = (sum_next + 2**(LOG2_LEN-1)) >>> LOG2_LEN, i.e. round half toward +inf. This cannot exceed the output range because the mean of in-range samples stays in range.
- Undefined: floor truncation as above.

Decomposition:
- Package mavg_pkg: localparam function for SUM_W, signed sample typedef parametrised by DATA_W, and a legality check for LOG2_LEN and DECIM (elaboration $error when out of range).
- Sub-module mavg_delay_line: circular buffer with write pointer. It returns the outgoing sample and exposes the wrap/fill flag.
- Top-level mavg_filter keeps the sum, decimation counter, rounding and output register.

Test Plan:
- LOG2_LEN=2, DECIM=1; ce with 16384, 8192, 0, -32768 -> rdy low for 3 samples, then on the 4th sample rdy pulses with avg=-2048. Then 16384 -> avg=-2048 again with rdy pulse.
- LOG2_LEN=2; samples 3,0,0,0 -> avg=0 truncated (1 with ROUND_EN). Samples -1,0,0,0 -> avg=-1 truncated (0 with ROUND_EN).
- LOG2_LEN=3, DECIM=4; constant 1000 for 20 samples -> rdy pulses on samples 8, 12, 16, 20 only, avg=1000 each time.
- Gaps: ce toggled 1/0 with samples 100,200,300,400 at LOG2_LEN=2 -> avg=250 once; avg and rdy hold during ce=0 cycles.
- clear asserted with ce after 2 of 4 samples (that sample dropped) -> next 4 samples of 400 give first rdy only after all 4, avg=400; avg holds the old value during refill. Same for async rst_n pulse mid-window, with avg=0 after reset.
- Full scale at DATA_W=16: all -32768 gives avg=-32768; all 32767 gives avg=32767, both with and without ROUND_EN.
